// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT twiddle scheduling logic.
package fft_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } twiddle_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // Latency (in samples) before stage s sees the first sample of a frame.
  function automatic int tw_offset(input int s, input int n);
    int off;
    off = 0;
    for (int j = 0; j < s; j++) begin
      off += n >> (j + 1);
    end
    return off;
  endfunction

endpackage

// File: rtl/twiddle_stage_pos.sv
// Position of one SDF stage within its window, giving butterfly/load half and twiddle address.
module twiddle_stage_pos
  import fft_pkg::*;
#(
  parameter int FFT_SIZE = 16,
  parameter int STAGES   = 4,
  parameter int IW       = 3,
  parameter int STAGE    = 0
) (
  input  logic [STAGES-1:0] cnt_i,
  output logic              bf_sel_o,
  output logic [IW-1:0]     index_o
);

  localparam logic [STAGES-1:0] OFF  = STAGES'(tw_offset(STAGE, FFT_SIZE));
  localparam logic [STAGES-1:0] MASK = STAGES'((FFT_SIZE >> STAGE) - 1);
  localparam logic [STAGES-1:0] HALF = STAGES'(FFT_SIZE >> (STAGE + 1));

  logic [STAGES-1:0] pos;
  logic [STAGES-1:0] rel;

  // Window length is a power of two, so the modulo is a mask.
  assign pos      = (cnt_i - OFF) & MASK;
  assign rel      = pos - HALF;
  assign bf_sel_o = (pos >= HALF);
  assign index_o  = bf_sel_o ? IW'(rel << STAGE) : '0;

endmodule

// File: rtl/twiddle_sched.sv
// Twiddle address scheduler for a single-path delay-feedback FFT: tracks frames
// through IDLE/RUN/DRAIN and emits registered per-stage twiddle indexes.
module twiddle_sched
  import fft_pkg::*;
#(
  parameter  int FFT_SIZE = 16,
  localparam int STAGES   = $clog2(FFT_SIZE),
  localparam int IW       = $clog2(FFT_SIZE) - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  input  logic                   s_sop,
  input  logic                   flush,
  output logic [IW-1:0][IW-1:0]  indexes,
  output logic [IW-1:0]          bf_sel,
  output logic [IW-1:0]          stage_act,
  output logic                   idx_valid,
  output logic                   sop_err
);

  localparam logic [STAGES-1:0] OFF_LAST = STAGES'(tw_offset(IW - 1, FFT_SIZE));

  sched_state_t state_q, state_d;
  logic [STAGES-1:0] cnt_q, cnt_d;
  logic [STAGES-1:0] fcnt_q, fcnt_d;
  logic [STAGES-1:0] dcnt_q, dcnt_d;
  logic [IW-1:0][IW-1:0] idx_q, idx_d;
  logic [IW-1:0] bf_q, bf_d;
  logic [IW-1:0] act_q, act_d;
  logic vld_q, vld_d;
  logic err_q, err_d;

  // Decoded view of the sample accepted this cycle.
  logic              smp_take;
  logic              smp_err;
  logic              smp_drain;
  logic [STAGES-1:0] smp_cnt;
  logic [STAGES-1:0] smp_fill;
  logic [STAGES-1:0] smp_dcnt;

  logic [IW-1:0][IW-1:0] stg_idx;
  logic [IW-1:0]         stg_bf;
  logic [IW-1:0]         stg_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      idx_q   <= '0;
      bf_q    <= '0;
      act_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
      idx_q   <= idx_d;
      bf_q    <= bf_d;
      act_q   <= act_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    smp_take  = 1'b0;
    smp_err   = 1'b0;
    smp_drain = 1'b0;
    smp_cnt   = cnt_q;
    smp_fill  = fcnt_q;
    smp_dcnt  = '0;
    if (flush) begin
      state_d = IDLE;
    end else if (s_valid) begin
      unique case (state_q)
        IDLE: begin
          if (s_sop) begin
            smp_take = 1'b1;
            smp_cnt  = '0;
            smp_fill = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          smp_take = 1'b1;
          if (s_sop && (cnt_q != '0)) begin
            smp_err  = 1'b1;
            smp_cnt  = '0;
            smp_fill = '0;
          end else if (!s_sop && (cnt_q == '0)) begin
            // Counter wrapped with no new frame behind it: this is the first drain sample.
            smp_drain = 1'b1;
            smp_dcnt  = STAGES'(1);
            state_d   = (smp_dcnt >= OFF_LAST) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          smp_take = 1'b1;
          if (s_sop) begin
            smp_cnt  = '0;
            smp_fill = '0;
            state_d  = RUN;
          end else begin
            smp_drain = 1'b1;
            smp_dcnt  = dcnt_q + 1'b1;
            state_d   = (smp_dcnt >= OFF_LAST) ? IDLE : DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    dcnt_d = dcnt_q;
    idx_d  = idx_q;
    bf_d   = bf_q;
    act_d  = act_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    if (flush) begin
      cnt_d  = '0;
      fcnt_d = '0;
      dcnt_d = '0;
      idx_d  = '0;
      bf_d   = '0;
      act_d  = '0;
    end else if (smp_take) begin
      cnt_d  = smp_cnt + 1'b1;
      fcnt_d = (smp_fill >= OFF_LAST) ? OFF_LAST : smp_fill + 1'b1;
      dcnt_d = smp_dcnt;
      if (state_d == IDLE) begin
        cnt_d  = '0;
        fcnt_d = '0;
        dcnt_d = '0;
      end
      idx_d = stg_idx;
      bf_d  = stg_bf;
      act_d = stg_act;
      vld_d = 1'b1;
      err_d = smp_err;
    end
  end

  for (genvar gi = 0; gi < IW; gi++) begin : g_stage
    localparam logic [STAGES-1:0] OFF = STAGES'(tw_offset(gi, FFT_SIZE));

    twiddle_stage_pos #(
      .FFT_SIZE (FFT_SIZE),
      .STAGES   (STAGES),
      .IW       (IW),
      .STAGE    (gi)
    ) u_pos (
      .cnt_i    (smp_cnt),
      .bf_sel_o (stg_bf[gi]),
      .index_o  (stg_idx[gi])
    );

    // A stage is live once filled, and goes idle once its last frame sample has passed.
    if (gi == 0) begin : g_first
      assign stg_act[gi] = !smp_drain;
    end else begin : g_rest
      assign stg_act[gi] = (smp_fill >= OFF) && (!smp_drain || (smp_dcnt < OFF));
    end
  end

  assign indexes   = idx_q;
  assign bf_sel    = bf_q;
  assign stage_act = act_q;
  assign idx_valid = vld_q;
  assign sop_err   = err_q;

endmodule

// File: doc/twiddle_sched.md
TWIDDLE_SCHED -- requirements
Module: twiddle_sched

Interface
REQ-001 SHALL have parameter FFT_SIZE, default 16, meaning number of FFT points; power of two, 4..1024.
REQ-002 SHALL derive STAGES = $clog2(FFT_SIZE) and IW = $clog2(FFT_SIZE)-1, where IW is both the index width and the count of twiddled stages.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_valid  input  1  one sample enters stage 0 this cycle.
REQ-006 SHALL have port s_sop  input  1  start of frame, qualified by s_valid.
REQ-007 SHALL have port flush  input  1  single-cycle pulse that abandons all frames and returns to IDLE.
REQ-008 SHALL have port indexes  output  [IW-1:0][IW-1:0]  per-stage twiddle address for the twiddle generator.
REQ-009 SHALL have port bf_sel  output  [IW-1:0]  per-stage flag: 1 = butterfly half, 0 = feedback-load half.
REQ-010 SHALL have port stage_act  output  [IW-1:0]  stage s holds valid frame data.
REQ-011 SHALL have port idx_valid  output  1  indexes, bf_sel and stage_act are updated this cycle.
REQ-012 SHALL have port sop_err  output  1  one-cycle pulse on a mid-frame s_sop.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DRAIN.
REQ-014 IDLE -> RUN on s_valid&&s_sop; s_valid without s_sop in IDLE SHALL be ignored (no counting, idx_valid low).
REQ-015 In RUN and DRAIN, each s_valid SHALL advance a global counter cnt (STAGES bits, wraps N-1 -> 0) and a fill counter fcnt, which saturates at OFF_last = sum_{j<IW-1}(N>>(j+1)).
REQ-016 Stage s offset SHALL be OFF_s = sum_{j<s}(N>>(j+1)); for N=16, OFF = 0, 8, 12.
REQ-017 Stage position SHALL be p_s = (cnt - OFF_s) mod (N>>s), with H_s = N>>(s+1).
REQ-018 Per-stage outputs SHALL be bf_sel[s] = (p_s >= H_s) and indexes[s] = bf_sel[s] ? ((p_s - H_s) << s) : 0, truncated to IW bits.
REQ-019 stage_act[s] SHALL be 1 once fcnt >= OFF_s since the RUN entry.
REQ-020 All outputs SHALL be registered; values for the accepted sample SHALL appear 1 cycle after s_valid, with idx_valid high for exactly that cycle.
REQ-021 Cycles with s_valid low SHALL hold all index outputs and drive idx_valid low, so gaps are allowed.
REQ-022 An s_sop at cnt==0 in RUN SHALL be a legal back-to-back frame with no state change.
REQ-023 An s_sop at cnt!=0 SHALL pulse sop_err, force cnt=0, force fcnt=0 and clear stage_act; that sample counts as position 0.
REQ-024 RUN -> DRAIN SHALL occur when cnt wraps to 0 without s_sop on that sample; the DRAIN sample advances counters, and in DRAIN s_valid carries flush-zero samples.
REQ-025 DRAIN -> RUN SHALL occur on s_valid&&s_sop.
REQ-026 DRAIN -> IDLE SHALL occur after OFF_last further valids; stage_act[s] SHALL drop when drain valids >= OFF_s+H_s... precisely: when stage s has output its last frame sample.
REQ-027 flush SHALL override all other inputs and, on the next edge, force IDLE with every output at its reset value.
REQ-028 flush and s_sop in the same cycle SHALL give flush priority, and the sample SHALL be dropped.

Reset
REQ-029 On rst_n low, state SHALL be IDLE, cnt and fcnt 0, indexes all 0, bf_sel 0, stage_act 0, idx_valid 0 and sop_err 0, asynchronously.
REQ-030 Reset SHALL be released synchronously to clk.
REQ-031 Reset mid-frame SHALL discard the frame, and the first frame after reset SHALL require s_sop.

Structure
REQ-032 fft_pkg SHALL hold the state enum sched_state_t and a function tw_offset(s, N) returning OFF_s; twiddle_t is already defined there.
REQ-033 A single sub-module twiddle_stage_pos SHALL be instantiated per stage via generate, computing p_s, bf_sel and the index from cnt.
REQ-034 indexes SHALL connect directly to the twiddle generator's indexes port, whose twiddles follow 1 cycle after indexes.

Verification
REQ-035 N=16, sop plus 16 continuous valids: stage0 indexes = 0 x8 then 0..7; stage1 (from cycle 9) 0,0,0,0,0,2,4,6...; stage2 stage_act rises on the 13th valid.
REQ-036 Same frame with s_valid every 3rd cycle: identical index sequence, and idx_valid pulses only one cycle after each valid.
REQ-037 sop at cnt=5: sop_err pulses once, stage0 restarts at position 0, and stage_act resets to 3'b001.
REQ-038 Two back-to-back frames then 12 valids without sop: RUN->DRAIN->IDLE, and stage_act clears stage by stage ending at 0.
REQ-039 flush asserted at cnt=9: next cycle IDLE with all outputs 0, and a following non-sop valid is ignored.
REQ-040 rst_n pulsed low asynchronously mid-frame: outputs 0 immediately, and a new sop restarts at position 0.
